vga_pixel_address: RTL and testbench

Free-running raster position counter for the VGA output path. It produces the current `column` and `row` of the whole VGA frame, including blanking and sync intervals. It advances one pixel per enabled clock and wraps at the end of each line and frame. Downstream sync generation, visible-area decode and framebuffer addressing all consume its outputs.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_wrap_counter.sv | 36 +++
 rtl/vga_pixel_address.sv | 64 ++++++
 tb/tb_vga_pixel_address.sv | 134 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and the 10-bit raster coordinate type.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COORD_MAX_COUNT = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned VGA640_H_VISIBLE     = 640;
  localparam int unsigned VGA640_H_FRONT_PORCH = 16;
  localparam int unsigned VGA640_H_SYNC        = 96;
  localparam int unsigned VGA640_H_BACK_PORCH  = 48;
  localparam int unsigned VGA640_H_WHOLE       = VGA640_H_VISIBLE + VGA640_H_FRONT_PORCH
                                               + VGA640_H_SYNC + VGA640_H_BACK_PORCH;

  localparam int unsigned VGA640_V_VISIBLE     = 480;
  localparam int unsigned VGA640_V_FRONT_PORCH = 10;
  localparam int unsigned VGA640_V_SYNC        = 2;
  localparam int unsigned VGA640_V_BACK_PORCH  = 33;
  localparam int unsigned VGA640_V_WHOLE       = VGA640_V_VISIBLE + VGA640_V_FRONT_PORCH
                                               + VGA640_V_SYNC + VGA640_V_BACK_PORCH;

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MODULUS counter with synchronous active-low clear; last_o flags MODULUS-1.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = 800
) (
  input  logic   clk,
  input  logic   clr_n_i,
  input  logic   inc_i,
  output coord_t value_o,
  output logic   last_o
);

  coord_t value_q;
  coord_t value_d;

  assign last_o = (value_q == coord_t'(MODULUS - 1));

  always_comb begin
    value_d = value_q;
    if (inc_i) begin
      value_d = last_o ? '0 : value_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/vga_pixel_address.sv
// Free-running VGA raster position (column/row incl. blanking).
// Optional `visible` decode enabled by defining VGA_PIXEL_ADDR_VISIBLE_EN.
module vga_pixel_address
  import vga_pkg::*;
#(
  parameter int unsigned H_WHOLE_LINE  = VGA640_H_WHOLE,
  parameter int unsigned V_WHOLE_FRAME = VGA640_V_WHOLE,
  parameter int unsigned H_VISIBLE     = VGA640_H_VISIBLE,
  parameter int unsigned V_VISIBLE     = VGA640_V_VISIBLE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] column,
  output logic [9:0] row
`ifdef VGA_PIXEL_ADDR_VISIBLE_EN
  ,
  output logic       visible
`endif
);

  if (H_WHOLE_LINE > COORD_MAX_COUNT || V_WHOLE_FRAME > COORD_MAX_COUNT ||
      H_WHOLE_LINE == 0 || V_WHOLE_FRAME == 0) begin : g_bad_params
    $error("vga_pixel_address: H_WHOLE_LINE/V_WHOLE_FRAME must be 1..1024");
  end

  coord_t col_q;
  coord_t row_q;
  logic   col_last;
  logic   row_last_unused;

  vga_wrap_counter #(
    .MODULUS (H_WHOLE_LINE)
  ) u_col (
    .clk     (clk),
    .clr_n_i (reset_n),
    .inc_i   (enable),
    .value_o (col_q),
    .last_o  (col_last)
  );

  // Row steps on the same edge the column wraps from H_WHOLE_LINE-1 to 0.
  vga_wrap_counter #(
    .MODULUS (V_WHOLE_FRAME)
  ) u_row (
    .clk     (clk),
    .clr_n_i (reset_n),
    .inc_i   (enable & col_last),
    .value_o (row_q),
    .last_o  (row_last_unused)
  );

  assign column = col_q;
  assign row    = row_q;

`ifdef VGA_PIXEL_ADDR_VISIBLE_EN
  always_comb begin
    visible = (int unsigned'(col_q) < H_VISIBLE) && (int unsigned'(row_q) < V_VISIBLE);
  end
`else
  localparam int unsigned VISIBLE_UNUSED = H_VISIBLE + V_VISIBLE;
`endif

endmodule

// File: tb/tb_vga_pixel_address.sv
// Scoreboard bench for vga_pixel_address; reduced frame height keeps runtime short.
module tb_vga_pixel_address;

  localparam int unsigned H_WHOLE = 800;
  localparam int unsigned V_WHOLE = 32;
  localparam int unsigned H_VIS   = 640;
  localparam int unsigned V_VIS   = 24;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [9:0] column;
  logic [9:0] row;
`ifdef VGA_PIXEL_ADDR_VISIBLE_EN
  logic       visible;
`endif

  typedef struct {
    string       name;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        vis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  vga_pixel_address #(
    .H_WHOLE_LINE  (H_WHOLE),
    .V_WHOLE_FRAME (V_WHOLE),
    .H_VISIBLE     (H_VIS),
    .V_VISIBLE     (V_VIS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .column  (column),
    .row     (row)
`ifdef VGA_PIXEL_ADDR_VISIBLE_EN
    ,
    .visible (visible)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pos(input string name, input int unsigned c, input int unsigned r,
                            input logic v);
    exp_t e;
    e.name = name;
    e.col  = 10'(c);
    e.row  = 10'(r);
    e.vis  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so compare on the falling edge after each expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if (column !== e.col || row !== e.row) begin
        errors = errors + 1;
        $display("FAIL %s: got col=%0d row=%0d, expected col=%0d row=%0d",
                 e.name, column, row, e.col, e.row);
      end
`ifdef VGA_PIXEL_ADDR_VISIBLE_EN
      checks = checks + 1;
      if (visible !== e.vis) begin
        errors = errors + 1;
        $display("FAIL %s_vis: got visible=%0b, expected %0b", e.name, visible, e.vis);
      end
`endif
    end
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;

    step(2);                       expect_pos("reset_hold", 0, 0, 1'b1);
    step(1); reset_n = 1'b1;       expect_pos("release_edge", 0, 0, 1'b1);
    step(1);                       expect_pos("first_count", 1, 0, 1'b1);
    step(1);                       expect_pos("second_count", 2, 0, 1'b1);

    step(797);                     expect_pos("line_end", 799, 0, 1'b0);
    step(1);                       expect_pos("line_wrap", 0, 1, 1'b1);
    step(800);                     expect_pos("row2", 0, 2, 1'b1);

    step(21 * 800);                expect_pos("row23", 0, 23, 1'b1);
    step(639);                     expect_pos("last_visible", 639, 23, 1'b1);
    step(1);                       expect_pos("h_blank", 640, 23, 1'b0);
    step(160);                     expect_pos("v_blank", 0, 24, 1'b0);
    step(7 * 800);                 expect_pos("last_row", 0, 31, 1'b0);
    step(800);                     expect_pos("frame_wrap", 0, 0, 1'b1);

    step(10 * 800 + 799);          expect_pos("pre_gate", 799, 10, 1'b0);
    enable = 1'b0;
    step(10);                      expect_pos("gated_hold", 799, 10, 1'b0);
    enable = 1'b1;
    step(1);                       expect_pos("gate_release", 0, 11, 1'b1);

    step(9 * 800 + 123);           expect_pos("pre_reset", 123, 20, 1'b1);
    reset_n = 1'b0;
    step(1);                       expect_pos("mid_reset", 0, 0, 1'b1);
    reset_n = 1'b1;
    step(1);                       expect_pos("post_reset", 1, 0, 1'b1);

    enable = 1'b0;
    reset_n = 1'b0;
    step(1);                       expect_pos("reset_no_enable", 0, 0, 1'b1);
    reset_n = 1'b1;

    // Drain: the monitor needs at most one falling edge per queued entry.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
